// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: pipelined RV32I instruction fetch with a prefetch FIFO.
// Request credits bound in-flight fetches so a response can always be queued.
module cpu_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   im_req_valid,
    input  logic                   im_req_ready,
    output logic [XLEN-1:0]        im_req_addr,
    input  logic                   im_rsp_valid,
    input  logic [31:0]            im_rsp_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [XLEN-1:0]        id_pc,
    output logic [XLEN-1:0]        id_pc4,
    output logic [31:0]            id_instr,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned     PW    = $clog2(DEPTH);
    localparam int unsigned     CW    = PW + 1;
    localparam logic [CW:0]     LIMIT = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(4);

    typedef enum logic {BOOT, RUN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   live_cnt_q, live_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];
    logic [XLEN-1:0] pc4_q   [DEPTH];
    logic [XLEN-1:0] pc4_d   [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];

    logic [XLEN-1:0] redir_pc;
    logic [CW:0]     live_plus_cnt;
    logic [CW:0]     live_plus_drop;
    logic            running;
    logic            req_fire;
    logic            rsp_take;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            redir_dec;

    assign redir_pc       = redirect_pc & ~XLEN'(3);
    assign running        = (state_q == RUN);
    assign live_plus_cnt  = {1'b0, live_cnt_q} + {1'b0, count_q};
    assign live_plus_drop = {1'b0, live_cnt_q} + {1'b0, drop_cnt_q};

    // Live credits reserve FIFO slots; total credits bound the memory queue.
    assign im_req_valid = running
                        & fetch_en
                        & ~redirect_valid
                        & (live_plus_cnt < LIMIT)
                        & (live_plus_drop < LIMIT);
    assign im_req_addr  = fetch_pc_q;
    assign req_fire     = im_req_valid & im_req_ready;

    assign id_valid   = (count_q != '0) & running;
    assign id_pc      = pc_q[rd_ptr_q];
    assign id_pc4     = pc4_q[rd_ptr_q];
    assign id_instr   = instr_q[rd_ptr_q];
    assign fifo_count = count_q;

    assign rsp_take  = im_rsp_valid & ~redirect_valid;
    assign rsp_drop  = rsp_take & (drop_cnt_q != '0);
    assign push      = rsp_take
                     & (drop_cnt_q == '0)
                     & (live_cnt_q != '0);
    assign pop       = id_valid & id_ready & ~redirect_valid;
    assign redir_dec = im_rsp_valid
                     & ((drop_cnt_q | live_cnt_q) != '0);

    always_comb begin
        state_d    = RUN;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_cnt_d = live_cnt_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        instr_d    = instr_q;
        if (redirect_valid) begin
            // Everything still in flight becomes a response to discard.
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            live_cnt_d = '0;
            drop_cnt_d = drop_cnt_q + live_cnt_q
                       - CW'(redir_dec);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (push) begin
                pc_d[wr_ptr_q]    = rsp_pc_q;
                pc4_d[wr_ptr_q]   = rsp_pc_q + STEP;
                instr_d[wr_ptr_q] = im_rsp_data;
                wr_ptr_d          = wr_ptr_q + PW'(1);
                rsp_pc_d          = rsp_pc_q + STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
            live_cnt_d = live_cnt_q + CW'(req_fire)
                       - CW'(push);
            count_d    = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_cnt_q <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_cnt_q <= live_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            instr_q    <= instr_d;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb_cpu_fetch_unit: randomized bench with a queue-based fetch model
// and a fixed-latency in-order instruction memory.
module tb_cpu_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    cpu_fetch_unit #(
        .XLEN(32),
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .im_req_valid(im_req_valid),
        .im_req_ready(im_req_ready),
        .im_req_addr(im_req_addr),
        .im_rsp_valid(im_rsp_valid),
        .im_rsp_data(im_rsp_data),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
        .id_pc4(id_pc4),
        .id_instr(id_instr),
        .fifo_count(fifo_count)
    );

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    typedef struct {logic [31:0] pc; bit keep;} fl_t;

    mreq_t       memq[$];
    fl_t         infl[$];
    logic [31:0] mfifo[$];
    logic [31:0] dut_pops[$];
    logic [31:0] dut_reqs[$];
    int          req_cyc[$];
    logic [31:0] m_fetch_pc;
    bit          running;
    bit          e_req;
    bit          e_idv;
    int          cyc;
    int          lat;
    int          n_tests;
    int          n_fail;
    logic [132:0] obs;
    logic [132:0] expv;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic reset_dut(input int l);
        rst = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        im_req_ready = 1'b0;
        id_ready = 1'b0;
        im_rsp_valid = 1'b0;
        im_rsp_data = 32'h0;
        lat = l;
        memq.delete();
        infl.delete();
        mfifo.delete();
        dut_pops.delete();
        dut_reqs.delete();
        req_cyc.delete();
        m_fetch_pc = RESET_PC;
        running = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Expected outputs for the cycle whose inputs are already driven.
    task automatic settle();
        int nlive;
        logic [31:0] hp;
        logic [31:0] hp4;
        @(negedge clk);
        nlive = 0;
        foreach (infl[i]) if (infl[i].keep) nlive++;
        e_req = running && fetch_en && !redirect_valid
             && (nlive + mfifo.size() < DEPTH)
             && (infl.size() < DEPTH);
        e_idv = running && (mfifo.size() > 0);
        hp = 32'h0;
        if (mfifo.size() > 0) hp = mfifo[0];
        hp4 = hp + 32'd4;
        expv = {e_req, e_req ? m_fetch_pc : 32'h0,
                e_idv, e_idv ? hp : 32'h0,
                e_idv ? hp4 : 32'h0,
                e_idv ? memf(hp) : 32'h0,
                3'(mfifo.size())};
        obs = {im_req_valid, e_req ? im_req_addr : 32'h0,
               id_valid, e_idv ? id_pc : 32'h0,
               e_idv ? id_pc4 : 32'h0,
               e_idv ? id_instr : 32'h0,
               fifo_count};
    endtask

    task automatic advance();
        if (im_req_valid && im_req_ready) begin
            memq.push_back('{im_req_addr, cyc + lat});
            dut_reqs.push_back(im_req_addr);
            req_cyc.push_back(cyc);
        end
        if (id_valid && id_ready && !redirect_valid)
            dut_pops.push_back(id_pc);
        if (redirect_valid) begin
            foreach (infl[i]) infl[i].keep = 1'b0;
            if (im_rsp_valid && infl.size() > 0) infl.delete(0);
            mfifo.delete();
            m_fetch_pc = redirect_pc & ~32'h3;
        end else begin
            if (e_idv && id_ready) mfifo.delete(0);
            if (im_rsp_valid && infl.size() > 0) begin
                if (infl[0].keep) mfifo.push_back(infl[0].pc);
                infl.delete(0);
            end
            if (e_req && im_req_ready) begin
                infl.push_back('{m_fetch_pc, 1'b1});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        running = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        im_rsp_valid = 1'b0;
        im_rsp_data = 32'h0;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            im_rsp_valid = 1'b1;
            im_rsp_data = memf(memq[0].addr);
            memq.delete(0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        im_req_ready = 1'b1;
        id_ready = 1'b1;
        im_rsp_valid = 1'b0;
        im_rsp_data = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (im_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got req=%b idv=%b want 0/0", im_req_valid, id_valid);
        end
        n_tests++;
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", fifo_count);
        end
        n_tests++;
        if ({id_pc, id_pc4, id_instr} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_head got %h %h %h want 0", id_pc, id_pc4, id_instr);
        end
    endtask

    task automatic test_stream();
        int c0;
        int first_idv;
        logic [31:0] f_pc;
        logic [31:0] f_pc4;
        reset_dut(1);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b1;
        c0 = cyc;
        first_idv = -1;
        f_pc = 32'hx;
        f_pc4 = 32'hx;
        for (int i = 0; i < 20; i++) begin
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL stream cyc=%0d got %h want %h", cyc, obs, expv);
            end
            if (first_idv < 0 && id_valid === 1'b1) begin
                first_idv = cyc;
                f_pc = id_pc;
                f_pc4 = id_pc4;
            end
            advance();
        end
        n_tests++;
        if (req_cyc.size() < 3 || req_cyc[0] != c0 + 1
            || req_cyc[1] != c0 + 2 || dut_reqs[0] !== 32'h0
            || dut_reqs[1] !== 32'h4 || dut_reqs[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL stream_first_reqs got n=%0d want 0,4,8 from cycle %0d", req_cyc.size(), c0 + 1);
        end
        n_tests++;
        if (first_idv != c0 + 3 || f_pc !== 32'h0 || f_pc4 !== 32'h4) begin
            n_fail++;
            $display("FAIL stream_latency got cyc=%0d pc=%h pc4=%h want cyc=%0d pc=0 pc4=4", first_idv, f_pc, f_pc4, c0 + 3);
        end
        n_tests++;
        if (dut_pops.size() != 17 || dut_pops[16] !== 32'h40) begin
            n_fail++;
            $display("FAIL stream_rate got %0d pops want 17", dut_pops.size());
        end
    endtask

    task automatic test_full();
        reset_dut(1);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL full_fill cyc=%0d got %h want %h", cyc, obs, expv);
            end
            advance();
        end
        n_tests++;
        if (dut_reqs.size() != 4 || fifo_count !== 3'd4 || im_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stop got reqs=%0d cnt=%0d req=%b want 4/4/0", dut_reqs.size(), fifo_count, im_req_valid);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL full_drain cyc=%0d got %h want %h", cyc, obs, expv);
            end
            advance();
        end
        n_tests++;
        if (dut_pops.size() < 4 || dut_pops[0] !== 32'h0 || dut_pops[1] !== 32'h4
            || dut_pops[2] !== 32'h8 || dut_pops[3] !== 32'hC) begin
            n_fail++;
            $display("FAIL full_order got n=%0d want 0,4,8,C", dut_pops.size());
        end
        n_tests++;
        if (dut_reqs.size() < 5 || dut_reqs[4] !== 32'h10) begin
            n_fail++;
            $display("FAIL full_resume got n=%0d want addr 10", dut_reqs.size());
        end
    endtask

    task automatic test_redirect();
        bit done;
        int rcyc;
        int pb;
        int rb;
        reset_dut(3);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b1;
        done = 1'b0;
        rcyc = 0;
        pb = 0;
        rb = 0;
        for (int i = 0; i < 30; i++) begin
            redirect_valid = !done && running && infl.size() == 3;
            redirect_pc = 32'h103;
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL redirect cyc=%0d got %h want %h", cyc, obs, expv);
            end
            if (redirect_valid) begin
                done = 1'b1;
                rcyc = cyc;
                pb = dut_pops.size();
                rb = dut_reqs.size();
            end
            advance();
            redirect_valid = 1'b0;
        end
        n_tests++;
        if (!done || dut_reqs.size() <= rb || dut_reqs[rb] !== 32'h100 || req_cyc[rb] != rcyc + 1) begin
            n_fail++;
            $display("FAIL redirect_req got done=%b n=%0d want addr 100 at cycle %0d", done, dut_reqs.size(), rcyc + 1);
        end
        n_tests++;
        if (dut_pops.size() <= pb || dut_pops[pb] !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_first_pc got n=%0d want pc 100", dut_pops.size());
        end
    endtask

    task automatic test_redirect_rsp_pop();
        bit done;
        int pb;
        reset_dut(1);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b1;
        done = 1'b0;
        pb = 0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = !done && running && im_rsp_valid && mfifo.size() > 0;
            redirect_pc = 32'h2002;
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rdr_rsp_pop cyc=%0d got %h want %h", cyc, obs, expv);
            end
            if (redirect_valid) begin
                done = 1'b1;
                pb = dut_pops.size();
                advance();
                redirect_valid = 1'b0;
                n_tests++;
                if (fifo_count !== 3'd0 || id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rdr_rsp_pop_flush got cnt=%0d idv=%b want 0/0", fifo_count, id_valid);
                end
            end else begin
                advance();
            end
        end
        n_tests++;
        if (!done || dut_pops.size() <= pb + 2 || dut_pops[pb] !== 32'h2000
            || dut_pops[pb + 1] !== 32'h2004) begin
            n_fail++;
            $display("FAIL rdr_rsp_pop_stream got done=%b n=%0d want 2000,2004", done, dut_pops.size());
        end
    endtask

    task automatic test_back_to_back();
        reset_dut(2);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            redirect_valid = (i == 5) || (i == 6);
            redirect_pc = (i == 5) ? 32'h40 : 32'hFFFF_FFF6;
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got %h want %h", cyc, obs, expv);
            end
            if (i == 6) dut_pops.delete();
            advance();
        end
        redirect_valid = 1'b0;
        n_tests++;
        if (dut_pops.size() < 4 || dut_pops[0] !== 32'hFFFF_FFF4 || dut_pops[1] !== 32'hFFFF_FFF8
            || dut_pops[2] !== 32'hFFFF_FFFC || dut_pops[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_wrap got n=%0d want FFFFFFF4..0", dut_pops.size());
        end
    endtask

    task automatic test_fetch_en();
        int rb;
        reset_dut(3);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b0;
        rb = -1;
        for (int i = 0; i < 14; i++) begin
            if (running && infl.size() == 2 && rb < 0) begin
                fetch_en = 1'b0;
                rb = dut_reqs.size();
            end
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL fetch_en cyc=%0d got %h want %h", cyc, obs, expv);
            end
            advance();
        end
        n_tests++;
        if (rb != 2 || dut_reqs.size() != 2 || fifo_count !== 3'd2) begin
            n_fail++;
            $display("FAIL fetch_en_hold got reqs=%0d cnt=%0d want 2/2", dut_reqs.size(), fifo_count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            reset_dut(int'($urandom_range(1, 3)));
            for (int i = 0; i < 300; i++) begin
                fetch_en = ($urandom % 8) != 0;
                im_req_ready = ($urandom % 4) != 0;
                id_ready = ($urandom % 3) != 0;
                redirect_valid = ($urandom % 25) == 0;
                redirect_pc = $urandom;
                settle();
                n_tests++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d got %h want %h", cyc, obs, expv);
                end
                advance();
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut(1);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL async_pre cyc=%0d got %h want %h", cyc, obs, expv);
            end
            advance();
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (im_req_valid !== 1'b0 || id_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL async_clear got req=%b idv=%b cnt=%0d want 0/0/0", im_req_valid, id_valid, fifo_count);
        end
        reset_dut(1);
        fetch_en = 1'b1;
        im_req_ready = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL async_post cyc=%0d got %h want %h", cyc, obs, expv);
            end
            advance();
        end
        n_tests++;
        if (dut_reqs.size() == 0 || dut_reqs[0] !== RESET_PC) begin
            n_fail++;
            $display("FAIL async_restart got n=%0d want first addr %h", dut_reqs.size(), RESET_PC);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        lat = 1;
        running = 1'b0;
        m_fetch_pc = RESET_PC;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_rsp_pop();
        test_back_to_back();
        test_fetch_en();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

endmodule
